dcache_wt: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the core's MEM stage and main data memory in the pipelined core. Read hits are answered combinationally in the same cycle. Read misses refill a whole line with a per-word request/acknowledge handshake, and writes are forwarded to memory. While the cache is busy it raises `stall`, which the hazard logic uses to freeze the pipeline.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_tag_array.sv | 39 +++
 rtl/dcache_wt.sv | 201 ++++++++++++++++++++
 tb/tb_dcache_wt.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the write-through data cache.
// Default-geometry field widths; instantiations derive their own from their parameters.
package dcache_pkg;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

   localparam int DEF_LINES  = 16;
   localparam int DEF_WORDS  = 4;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_OFF_W  = $clog2(DEF_WORDS);
   localparam int DEF_IDX_W  = $clog2(DEF_LINES);
   localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 2;

   // Extracts a w-bit field starting at bit lsb of a byte address.
   function automatic logic [63:0] addr_field(input logic [63:0] a,
                                              input int unsigned lsb,
                                              input int unsigned w);
      return (a >> lsb) & ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid bits and tags: combinational lookup, one write port, bulk invalidate.
// Invalidate wins over a same-edge write; tags are not reset, valid bits are.
module dcache_tag_array #(
   parameter int LINES = 16,
   parameter int TAG_W = 24,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] lk_idx,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             hit,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             wr_valid,
   input  logic             inval_all
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
      end else if (inval_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) tags[wr_idx] <= wr_tag;
   end

   assign hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate D-cache; read hit 0 cycles, misses refill per-word.
// stall holds the core while refilling or writing; optional counters under DCACHE_WT_STATS_EN.
module dcache_wt
   import dcache_pkg::*;
#(
   parameter int LINES  = 16,
   parameter int WORDS  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              flush,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
`ifdef DCACHE_WT_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
   output logic [31:0]       wr_cnt
`endif
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

   logic [TAG_W-1:0] a_tag;
   logic [IDX_W-1:0] a_idx;
   logic [OFF_W-1:0] a_word;

   assign a_word = OFF_W'(addr_field(64'(addr), 2, OFF_W));
   assign a_idx  = IDX_W'(addr_field(64'(addr), 2 + OFF_W, IDX_W));
   assign a_tag  = TAG_W'(addr_field(64'(addr), 2 + OFF_W + IDX_W, TAG_W));

   state_t                    state, state_nx;
   logic [OFF_W-1:0]          beat, beat_nx, beat_inc;
   logic                      wr_done, wr_done_nx, flush_pend, flush_pend_nx;
   logic                      mem_req_nx, mem_we_nx;
   logic [ADDR_W-1:0]         mem_addr_nx;
   logic [31:0]               mem_wdata_nx;
   logic                      hit, tag_we, tag_wvalid, inval_all;
   logic                      dat_we;
   logic [IDX_W+OFF_W-1:0]    dat_widx;
   logic [31:0]               dat_wval;
   logic [31:0]               data [LINES*WORDS];

   assign beat_inc = beat + OFF_W'(1);

   dcache_tag_array #(.LINES(LINES), .TAG_W(TAG_W)) u_tags (
      .clk       (clk),
      .reset     (reset),
      .lk_idx    (a_idx),
      .lk_tag    (a_tag),
      .hit       (hit),
      .wr_en     (tag_we),
      .wr_idx    (a_idx),
      .wr_tag    (a_tag),
      .wr_valid  (tag_wvalid),
      .inval_all (inval_all)
   );

   always_comb begin
      state_nx      = state;
      beat_nx       = beat;
      wr_done_nx    = 1'b0;
      flush_pend_nx = flush_pend;
      mem_req_nx    = mem_req;
      mem_we_nx     = mem_we;
      mem_addr_nx   = mem_addr;
      mem_wdata_nx  = mem_wdata;
      tag_we        = 1'b0;
      tag_wvalid    = 1'b0;
      inval_all     = 1'b0;
      dat_we        = 1'b0;
      dat_widx      = {a_idx, a_word};
      dat_wval      = wdata;
      stall         = 1'b0;
      rdata         = '0;
      case (state)
         IDLE: begin
            inval_all     = flush;
            flush_pend_nx = 1'b0;
            mem_req_nx    = 1'b0;
            mem_we_nx     = 1'b0;
            mem_addr_nx   = '0;
            mem_wdata_nx  = '0;
            if (req && we) begin
               stall = !wr_done;
               // wr_done marks the release cycle of a store already sent to memory
               if (!wr_done) begin
                  state_nx     = WRITE;
                  mem_req_nx   = 1'b1;
                  mem_we_nx    = 1'b1;
                  mem_addr_nx  = {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_nx = wdata;
                  dat_we       = hit;
               end
            end else if (req) begin
               if (hit) begin
                  rdata = data[{a_idx, a_word}];
               end else begin
                  stall       = 1'b1;
                  state_nx    = REFILL;
                  beat_nx     = '0;
                  tag_we      = 1'b1;
                  mem_req_nx  = 1'b1;
                  mem_addr_nx = {addr[ADDR_W-1:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
               end
            end
         end
         REFILL: begin
            stall = 1'b1;
            if (flush) flush_pend_nx = 1'b1;
            if (mem_req && mem_ack) begin
               dat_we   = 1'b1;
               dat_widx = {a_idx, beat};
               dat_wval = mem_rdata;
               beat_nx  = beat_inc;
               if (beat == OFF_W'(WORDS - 1)) begin
                  tag_we        = 1'b1;
                  tag_wvalid    = 1'b1;
                  inval_all     = flush_pend || flush;
                  flush_pend_nx = 1'b0;
                  state_nx      = IDLE;
                  beat_nx       = '0;
                  mem_req_nx    = 1'b0;
                  mem_addr_nx   = '0;
               end else begin
                  mem_addr_nx = {addr[ADDR_W-1:OFF_W+2], beat_inc, 2'b00};
               end
            end
         end
         WRITE: begin
            stall = 1'b1;
            if (flush) flush_pend_nx = 1'b1;
            if (mem_req && mem_ack) begin
               inval_all     = flush_pend || flush;
               flush_pend_nx = 1'b0;
               state_nx      = IDLE;
               wr_done_nx    = 1'b1;
               mem_req_nx    = 1'b0;
               mem_we_nx     = 1'b0;
               mem_addr_nx   = '0;
               mem_wdata_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         beat       <= '0;
         wr_done    <= 1'b0;
         flush_pend <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_nx;
         beat       <= beat_nx;
         wr_done    <= wr_done_nx;
         flush_pend <= flush_pend_nx;
         mem_req    <= mem_req_nx;
         mem_we     <= mem_we_nx;
         mem_addr   <= mem_addr_nx;
         mem_wdata  <= mem_wdata_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (dat_we) data[dat_widx] <= dat_wval;
   end

`ifdef DCACHE_WT_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wr_cnt   <= '0;
      end else begin
         if (state == IDLE && req && !we && hit) hit_cnt <= hit_cnt + 32'd1;
         if (state == IDLE && state_nx == REFILL) miss_cnt <= miss_cnt + 32'd1;
         if (state == IDLE && req && we && wr_done) wr_cnt <= wr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: scoreboarded memory transactions plus load/store results.
module tb_dcache_wt;

   logic        clk = 1'b0, reset = 1'b0, req = 1'b0, we = 1'b0, flush = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic        stall, mem_req, mem_we;
`ifdef DCACHE_WT_STATS_EN
   logic [31:0] hit_cnt, miss_cnt, wr_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   txn_t        e;
   logic [31:0] mem [logic [31:0]];

   dcache_wt dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .flush     (flush),
      .rdata     (rdata),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
`ifdef DCACHE_WT_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
      .wr_cnt    (wr_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hA0 + ((a - 32'h100) >> 2);
   endfunction

   task automatic push_refill(input logic [31:0] base);
      for (int k = 0; k < 4; k++) exp_q.push_back('{we: 1'b0, addr: base + 32'(4 * k), data: 32'h0});
   endtask

   // Memory: acknowledges each request one negedge after it is seen, never twice in a row.
   always @(negedge clk) begin
      if (mem_req && !mem_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected got we=%b addr=%h data=%h required no access", mem_we, mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
               errors++;
               $display("FAIL mem_txn got we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                        mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
         end
         if (mem_we) mem[mem_addr] = mem_wdata;
         else mem_rdata = memval(mem_addr);
         mem_ack = 1'b1;
      end else begin
         mem_ack = 1'b0;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the retiring edge. cyc = stalled cycles, -1 on timeout.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int cyc);
      bit done;
      req = 1'b1; we = w; addr = a; wdata = d;
      cyc = 0; rd = '0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (!stall) begin
            done = 1; rd = rdata;
         end else begin
            cyc++;
            if (cyc > 100) begin cyc = -1; done = 1; end
         end
      end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl got stall/mem_req/mem_we=%b required 000", {stall, mem_req, mem_we});
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
         errors++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h required 0", mem_addr, mem_wdata, rdata);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_cold_load();
      logic [31:0] rd; int cyc;
      push_refill(32'h100);
      access(1'b0, 32'h100, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL cold_rdata got %h required a0", rd); end
      checks++; if (cyc !== 8) begin errors++; $display("FAIL cold_stall got %0d required 8", cyc); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cold_beats got %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_hit();
      logic [31:0] rd; int cyc;
      access(1'b0, 32'h108, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hA2) begin errors++; $display("FAIL hit_rdata got %h required a2", rd); end
      checks++; if (cyc !== 0) begin errors++; $display("FAIL hit_stall got %0d required 0", cyc); end
   endtask

   task automatic test_store_hit();
      logic [31:0] rd; int cyc;
      exp_q.push_back('{we: 1'b1, addr: 32'h104, data: 32'hDEAD});
      access(1'b1, 32'h104, 32'hDEAD, rd, cyc);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL st_hit_stall got %0d required 2", cyc); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL st_hit_write got %0d left required 0", exp_q.size()); end
      access(1'b0, 32'h104, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hDEAD) begin errors++; $display("FAIL st_hit_load got %h required dead", rd); end
      checks++; if (cyc !== 0) begin errors++; $display("FAIL st_hit_load_stall got %0d required 0", cyc); end
   endtask

   task automatic test_store_miss();
      logic [31:0] rd; int cyc;
      exp_q.push_back('{we: 1'b1, addr: 32'h2000, data: 32'h1234_5678});
      access(1'b1, 32'h2000, 32'h1234_5678, rd, cyc);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL st_miss_stall got %0d required 2", cyc); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL st_miss_write got %0d left required 0", exp_q.size()); end
      push_refill(32'h2000);
      access(1'b0, 32'h2000, 32'h0, rd, cyc);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL st_miss_load got %h required 12345678", rd); end
      checks++; if (cyc !== 8) begin errors++; $display("FAIL st_miss_refill got %0d required 8", cyc); end
   endtask

   task automatic test_conflict();
      logic [31:0] rd; int cyc;
      push_refill(32'h200);
      access(1'b0, 32'h200, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hE0) begin errors++; $display("FAIL conf_a_rdata got %h required e0", rd); end
      checks++; if (cyc !== 8) begin errors++; $display("FAIL conf_a_stall got %0d required 8", cyc); end
      push_refill(32'h100);
      access(1'b0, 32'h104, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hDEAD) begin errors++; $display("FAIL conf_b_rdata got %h required dead", rd); end
      checks++; if (cyc !== 8) begin errors++; $display("FAIL conf_b_stall got %0d required 8", cyc); end
   endtask

   task automatic test_flush_refill();
      logic [31:0] rd; int cyc;
      push_refill(32'h200);
      push_refill(32'h200);
      fork
         access(1'b0, 32'h204, 32'h0, rd, cyc);
         begin
            int n = 0;
            while (mem_addr !== 32'h204 && n < 50) begin @(negedge clk); n++; end
            checks++;
            if (n >= 50) begin
               errors++; $display("FAIL flush_beat2 got no beat at 204 required one");
            end else begin
               flush = 1'b1;
               @(posedge clk); #1;
               flush = 1'b0;
            end
         end
      join
      checks++; if (rd !== 32'hE1) begin errors++; $display("FAIL flush_rf_rdata got %h required e1", rd); end
      checks++; if (cyc !== 16) begin errors++; $display("FAIL flush_rf_stall got %0d required 16", cyc); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL flush_rf_beats got %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_flush_idle();
      logic [31:0] rd; int cyc;
      access(1'b0, 32'h204, 32'h0, rd, cyc);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL flush_idle_hit got %0d required 0", cyc); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      push_refill(32'h200);
      access(1'b0, 32'h20C, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hE3) begin errors++; $display("FAIL flush_idle_rdata got %h required e3", rd); end
      checks++; if (cyc !== 8) begin errors++; $display("FAIL flush_idle_miss got %0d required 8", cyc); end
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] rd; int cyc;
      exp_q.push_back('{we: 1'b0, addr: 32'h100, data: 32'h0});
      req = 1'b1; we = 1'b0; addr = 32'h100;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0; req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_memreq got %b required 0", mem_req); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_mid_beats got %0d left required 0", exp_q.size()); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      push_refill(32'h100);
      access(1'b0, 32'h100, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL rst_mid_rdata got %h required a0", rd); end
      checks++; if (cyc !== 8) begin errors++; $display("FAIL rst_mid_miss got %0d required 8", cyc); end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cold_load();
      test_hit();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_flush_refill();
      test_flush_idle();
      test_reset_mid_refill();
      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL final_queue got %0d left required 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
